// File: rtl/capture_buffer_pkg.sv
// rtl/capture_buffer_pkg.sv - shared state and mode definitions for the capture buffer
package capture_buffer_pkg;

  // Capture sequencer states; IDLE doubles as the free-running ring mode
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    WAIT = 3'd2,
    POST = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic MODE_CONT = 1'b0;
  localparam logic MODE_TRIG = 1'b1;

endpackage

// File: rtl/capture_buffer_sdp_ram.sv
// rtl/capture_buffer_sdp_ram.sv - read-first simple dual-port sample RAM with lane select
module capture_buffer_sdp_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int NUM_CH = 2,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int WORD_W = NUM_CH * DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [DATA_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rd_word;
  logic [CH_W-1:0]   rd_ch_q;

  // All lanes of one beat land in a single wide word
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read; non-blocking update gives old data on a same-address write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_word <= '0;
      rd_ch_q <= '0;
    end else if (rd_en) begin
      rd_word <= mem[rd_addr];
      rd_ch_q <= rd_ch;
    end
  end

  // Lane select from the registered channel; unpopulated channel codes read as zero
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd_ch_q == CH_W'(k)) rd_data = rd_word[k*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/capture_buffer.sv
// rtl/capture_buffer.sv - multi-channel ring / triggered capture memory with logical readback
module capture_buffer
  import capture_buffer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int NUM_CH = 2,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic                     arm,
  input  logic [ADDR_W-1:0]        pre_trig,
  input  logic                     trigger,
  input  logic                     sample_valid,
  input  logic [NUM_CH*DATA_W-1:0] sample_in,
  input  logic                     rd_en,
  input  logic [CH_W-1:0]          rd_ch,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W-1:0]        trig_index,
  output logic [ADDR_W:0]          wr_count
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] post;
  logic [ADDR_W-1:0] phys;
  logic              wr_fire;

  // The buffer freezes only once a triggered capture has completed
  assign wr_fire = (state != DONE) && sample_valid;

  // Logical index 0 is the oldest sample still held since arm/reset
  assign phys = wr_ptr - wr_count[ADDR_W-1:0] + rd_addr;

  // Write pointer free-runs; the stored-sample count restarts on every arm
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      wr_count <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (arm) wr_count <= '0;
      else if (wr_fire && (wr_count != (ADDR_W+1)'(DEPTH))) wr_count <= wr_count + 1'b1;
    end
  end

  // Capture sequencer with registered busy/done; arm always wins over trigger.
  // pre_trig is ADDR_W bits wide, so it can never exceed DEPTH-1 and needs no clamp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= '0;
      post       <= '0;
      trig_index <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (arm) begin
      pc   <= pre_trig;
      done <= 1'b0;
      if (mode == MODE_TRIG) begin
        state <= (pre_trig == '0) ? WAIT : PRE;
        busy  <= 1'b1;
      end else begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end else begin
      case (state)
        PRE: begin
          if (wr_fire && ((wr_count + 1'b1) == {1'b0, pc})) state <= WAIT;
        end
        WAIT: begin
          if (sample_valid && trigger) begin
            trig_index <= wr_ptr;
            post       <= LAST - pc;
            if (pc == LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= POST;
            end
          end
        end
        POST: begin
          if (sample_valid) begin
            post <= post - 1'b1;
            if (post == ADDR_W'(1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Read strobe qualifier follows the RAM's one-cycle latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_valid <= 1'b0;
    else        rd_valid <= rd_en;
  end

  capture_buffer_sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .NUM_CH (NUM_CH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_fire),
    .wr_addr (wr_ptr),
    .wr_data (sample_in),
    .rd_en   (rd_en),
    .rd_addr (phys),
    .rd_ch   (rd_ch),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_capture_buffer.sv
// tb/tb_capture_buffer.sv - randomized self-checking bench for capture_buffer
module tb_capture_buffer;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode, arm, trigger, sample_valid, rd_en;
  logic [7:0]  pre_trig, rd_addr;
  logic [31:0] sample_in;
  logic        rd_ch;
  logic [15:0] rd_data;
  logic        rd_valid, busy, done;
  logic [7:0]  trig_index;
  logic [8:0]  wr_count;

  // Second, tiny instance with three lanes so an unpopulated channel code exists
  logic        s_sv, s_rd_en;
  logic [23:0] s_in;
  logic [1:0]  s_rd_ch, s_rd_addr;
  logic [7:0]  s_rd_data;
  logic        s_rd_valid, s_busy, s_done;
  logic [1:0]  s_trig_index;
  logic [2:0]  s_wr_count;

  int vectors = 0;
  int errs    = 0;

  // Reference model: history of every stored beat since reset, plus capture phase
  logic [15:0] log0 [4096];
  logic [15:0] log1 [4096];
  int m_total, m_count, m_pc, m_left, m_phase, m_trig;

  capture_buffer #(.DATA_W(16), .DEPTH(DEPTH), .NUM_CH(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .arm(arm), .pre_trig(pre_trig),
    .trigger(trigger), .sample_valid(sample_valid), .sample_in(sample_in),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .done(done), .trig_index(trig_index),
    .wr_count(wr_count)
  );

  capture_buffer #(.DATA_W(8), .DEPTH(4), .NUM_CH(3)) u_small (
    .clk(clk), .rst_n(rst_n), .mode(1'b0), .arm(1'b0), .pre_trig(2'd0),
    .trigger(1'b0), .sample_valid(s_sv), .sample_in(s_in),
    .rd_en(s_rd_en), .rd_ch(s_rd_ch), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
    .rd_valid(s_rd_valid), .busy(s_busy), .done(s_done), .trig_index(s_trig_index),
    .wr_count(s_wr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_total = 0; m_count = 0; m_pc = 0; m_left = 0; m_phase = 0; m_trig = 0;
  endtask

  task automatic model_update(input bit sv, input logic [15:0] d0, input logic [15:0] d1,
                              input bit trg, input bit a, input bit md, input int pt);
    bit we;
    we = (m_phase != 4) && sv;
    if (we) begin
      log0[m_total] = d0;
      log1[m_total] = d1;
      m_total++;
    end
    if (a) begin
      m_count = 0;
      m_pc    = pt;
      m_phase = md ? ((pt == 0) ? 2 : 1) : 0;
    end else begin
      if (we && m_count < DEPTH) m_count++;
      case (m_phase)
        1: if (we && m_count == m_pc) m_phase = 2;
        2: if (sv && trg) begin
             m_trig  = (m_total - 1) % DEPTH;
             m_left  = DEPTH - 1 - m_pc;
             m_phase = (m_left == 0) ? 4 : 3;
           end
        3: if (sv) begin
             m_left--;
             if (m_left == 0) m_phase = 4;
           end
        default: ;
      endcase
    end
  endtask

  // One clock of stimulus; read expectation is taken from the model before the edge
  task automatic step(input bit sv, input logic [15:0] d0, input logic [15:0] d1, input bit trg,
                      input bit a, input bit md, input int pt, input bit re, input bit ch,
                      input int ad);
    int j;
    bit known;
    logic [15:0] exp_rd;
    sample_valid = sv; sample_in = {d1, d0}; trigger = trg; arm = a; mode = md;
    pre_trig = 8'(pt); rd_en = re; rd_ch = ch; rd_addr = 8'(ad);
    j = m_total - m_count + ad;
    if (j >= m_total) j -= DEPTH;
    known  = (j >= 0);
    exp_rd = known ? (ch ? log1[j] : log0[j]) : 16'h0;
    model_update(sv, d0, d1, trg, a, md, pt);
    @(posedge clk); #1;
    chk("rd_valid", 32'(rd_valid), 32'(re));
    if (re && known) chk("rd_data", 32'(rd_data), 32'(exp_rd));
    chk("busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= 3));
    chk("done", 32'(done), 32'(m_phase == 4));
    chk("wr_count", 32'(wr_count), 32'(m_count));
    chk("trig_index", 32'(trig_index), 32'(m_trig));
    sample_valid = 1'b0; trigger = 1'b0; arm = 1'b0; rd_en = 1'b0;
  endtask

  task automatic arm_cap(input bit md, input int pt);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, md, pt, 1'b0, 1'b0, 0);
  endtask

  task automatic rd_expect(input bit ch, input int ad, input int exp);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 0, 1'b1, ch, ad);
    chk("spec_rd", 32'(rd_data), 32'(exp));
  endtask

  // Feed samples ch0=i, ch1=i+1000 with random gaps, random reads, and stray triggers on idle beats
  task automatic feed(input int n_last, input int t0, input int t1, input int t2);
    int i;
    bit sv, tg;
    i = 0;
    while (i <= n_last) begin
      sv = ($urandom_range(3) != 0);
      tg = sv ? (i == t0 || i == t1 || i == t2) : ($urandom_range(1) == 1);
      step(sv, 16'(i), 16'(i + 1000), tg, 1'b0, 1'b0, 0,
           $urandom_range(1) == 1, $urandom_range(1) == 1, int'($urandom_range(255)));
      if (sv) i++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] old_v;
    rst_n = 1'b0; mode = 0; arm = 0; trigger = 0; sample_valid = 0; rd_en = 0;
    pre_trig = 0; rd_addr = 0; sample_in = 0; rd_ch = 0;
    s_sv = 0; s_rd_en = 0; s_in = 0; s_rd_ch = 0; s_rd_addr = 0;
    model_reset();
    #3;
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_trig_index", 32'(trig_index), 32'h0);
    chk("rst_wr_count", 32'(wr_count), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Continuous wrap
    feed(269, -1, -1, -1);
    chk("t1_wr_count", 32'(wr_count), 32'd256);
    rd_expect(1'b0, 0, 14);
    rd_expect(1'b0, 255, 269);
    rd_expect(1'b1, 0, 1014);

    // Triggered capture from wr_ptr=0
    do_reset();
    arm_cap(1'b1, 16);
    feed(400, 100, -1, -1);
    chk("t2_trig_index", 32'(trig_index), 32'd100);
    chk("t2_done", 32'(done), 32'd1);
    rd_expect(1'b0, 16, 100);
    rd_expect(1'b0, 0, 84);
    rd_expect(1'b0, 255, 339);

    // Triggers during PRE are ignored
    arm_cap(1'b1, 16);
    feed(300, 5, 15, 20);
    rd_expect(1'b0, 16, 20);
    rd_expect(1'b0, 0, 4);

    // No pre-trigger history
    arm_cap(1'b1, 0);
    feed(300, 0, -1, -1);
    rd_expect(1'b0, 0, 0);
    rd_expect(1'b0, 255, 255);

    // Maximum pre-trigger depth: trigger sample is the last one
    arm_cap(1'b1, 255);
    feed(260, 100, 255, -1);
    chk("t4b_done", 32'(done), 32'd1);
    rd_expect(1'b0, 255, 255);
    rd_expect(1'b0, 0, 0);

    // Reset during POST aborts at once
    arm_cap(1'b1, 16);
    feed(100, 30, -1, -1);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 0);
    chk("t5_busy_pre", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_done", 32'(done), 32'h0);
    chk("t5_rd_valid", 32'(rd_valid), 32'h0);
    chk("t5_wr_count", 32'(wr_count), 32'h0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    arm_cap(1'b1, 16);
    feed(300, 40, -1, -1);
    chk("t5_done_again", 32'(done), 32'd1);
    rd_expect(1'b0, 16, 40);

    // Read-first on same physical address, continuous mode
    arm_cap(1'b0, 0);
    feed(9, -1, -1, -1);
    step(1'b1, 16'hAAAA, 16'hBBBB, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, m_count);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
    feed(300, -1, -1, -1);
    old_v = log0[m_total - DEPTH];
    step(1'b1, 16'h5555, 16'h6666, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 0);
    chk("t6_rw_old", 32'(rd_data), 32'(old_v));

    // Channel code beyond NUM_CH reads zero
    s_sv = 1'b1; s_in = 24'h332211;
    @(posedge clk); #1;
    s_sv = 1'b0; s_rd_en = 1'b1; s_rd_ch = 2'd2; s_rd_addr = 2'd0;
    @(posedge clk); #1;
    chk("t6_ch2", 32'(s_rd_data), 32'h33);
    chk("t6_small_cnt", 32'(s_wr_count), 32'd1);
    s_rd_ch = 2'd3;
    @(posedge clk); #1;
    chk("t6_ch3_zero", 32'(s_rd_data), 32'h0);
    chk("t6_ch3_valid", 32'(s_rd_valid), 32'd1);
    s_rd_en = 1'b0;
    @(posedge clk); #1;
    chk("t6_small_idle", 32'({s_rd_valid, s_busy, s_done, s_trig_index}), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
